// File: rtl/cmp_arb_pkg.sv
// Shared types and defaults for the round-robin compare arbiter.
// The optional signed build is selected by defining CMP_ARB_SIGNED_EN.
package cmp_arb_pkg;

   localparam int CMP_ARB_NUM_REQ = 4;
   localparam int CMP_ARB_WIDTH   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } cmp_arb_state_e;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_result_t;

   // The ID field stays one bit wide even when there is a single requester.
   function automatic int cmp_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between client FSMs (master) and the shared comparator (slave).
// Signal set is identical whether or not CMP_ARB_SIGNED_EN is defined.
interface cmp_arbiter_if
   import cmp_arb_pkg::*;
#(
   parameter int NUM_REQ = CMP_ARB_NUM_REQ,
   parameter int WIDTH   = CMP_ARB_WIDTH,
   parameter int ID_W    = cmp_id_w(NUM_REQ)
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic                     rsp_gt;
   logic                     rsp_lt;
   logic                     rsp_eq;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq
   );

endinterface

// File: rtl/cmp_rr_picker.sv
// Combinational round-robin search: first set request starting at rr_ptr, wrapping.
// Used identically in both the signed (CMP_ARB_SIGNED_EN) and unsigned builds.
module cmp_rr_picker
   import cmp_arb_pkg::*;
#(
   parameter int NUM_REQ = CMP_ARB_NUM_REQ,
   parameter int ID_W    = cmp_id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_req
);

   localparam logic [ID_W:0] NUM_W = (ID_W+1)'(NUM_REQ);

   logic [NUM_REQ-1:0] rot_req;
   logic [ID_W-1:0]    rot_idx [NUM_REQ];

   // Slot gi of the rotated view is requester (rr_ptr + gi) mod NUM_REQ.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         logic [ID_W:0] sum;
         assign sum          = {1'b0, rr_ptr} + (ID_W+1)'(gi);
         assign rot_idx[gi]  = (sum >= NUM_W) ? ID_W'(sum - NUM_W) : sum[ID_W-1:0];
         assign rot_req[gi]  = req[rot_idx[gi]];
      end
   endgenerate

   always_comb begin
      grant_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_req[k]) begin
            grant_idx = rot_idx[k];
         end
      end
      any_req = |req;
      grant   = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one registered magnitude comparator among NUM_REQ clients.
// Define CMP_ARB_SIGNED_EN to compare operands as two's-complement (gt/lt only).
module cmp_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int NUM_REQ = CMP_ARB_NUM_REQ,
   parameter int WIDTH   = CMP_ARB_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   cmp_arbiter_if.slave bus
);

   localparam int              ID_W    = cmp_id_w(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   cmp_arb_state_e     state_reg, state_next;
   logic [ID_W-1:0]    rr_ptr_reg, id_reg, rsp_id_reg;
   logic [ID_W-1:0]    grant_idx, ptr_next;
   logic [WIDTH-1:0]   a_reg, b_reg;
   logic               rsp_valid_reg;
   cmp_result_t        result_reg, cmp_res;
   logic [NUM_REQ-1:0] grant;
   logic               any_req, accept;
   logic [WIDTH-1:0]   a_arr [NUM_REQ];
   logic [WIDTH-1:0]   b_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
      end
   endgenerate

   cmp_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req       (bus.req_valid),
      .rr_ptr    (rr_ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   assign accept   = (state_reg == IDLE) && any_req;
   assign ptr_next = (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (any_req) state_next = CMP;
         CMP:     state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg    <= '0;
         id_reg        <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         rsp_id_reg    <= '0;
         result_reg    <= '0;
         rsp_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            a_reg      <= a_arr[grant_idx];
            b_reg      <= b_arr[grant_idx];
            id_reg     <= grant_idx;
            rr_ptr_reg <= ptr_next;
         end
         // Flags are only rewritten in CMP, so they hold after the response is taken.
         if (state_reg == CMP) begin
            result_reg    <= cmp_res;
            rsp_id_reg    <= id_reg;
            rsp_valid_reg <= 1'b1;
         end else if (state_reg == RESP && bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (rst_n && state_reg == IDLE) begin
         bus.req_ready = grant;
      end
      cmp_res = '0;
`ifdef CMP_ARB_SIGNED_EN
      cmp_res.gt = $signed(a_reg) > $signed(b_reg);
      cmp_res.lt = $signed(a_reg) < $signed(b_reg);
`else
      cmp_res.gt = a_reg > b_reg;
      cmp_res.lt = a_reg < b_reg;
`endif
      cmp_res.eq = a_reg == b_reg;
   end

   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_gt    = result_reg.gt;
   assign bus.rsp_lt    = result_reg.lt;
   assign bus.rsp_eq    = result_reg.eq;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized bench for cmp_arbiter against a transaction-level reference model.
// Define CMP_ARB_SIGNED_EN for both RTL and bench to exercise the signed build.
module tb_cmp_arbiter;
   import cmp_arb_pkg::*;

   localparam int N = 4;
   localparam int W = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cmp_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();

   cmp_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   // Reference model: one outstanding operation, response visible two cycles after acceptance.
   bit m_busy = 1'b0;
   int m_ptr  = 0;
   int m_acc  = 0;
   int m_id   = 0;
   int m_a    = 0;
   int m_b    = 0;
   int acc_log[$];
   int acc_cyc_log[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] ref_flags(input int a, input int b);
      int sa = a;
      int sb = b;
`ifdef CMP_ARB_SIGNED_EN
      if (sa >= (1 << (W - 1))) sa -= (1 << W);
      if (sb >= (1 << (W - 1))) sb -= (1 << W);
`endif
      return {sa > sb, sa < sb, sa == sb};
   endfunction

   function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // Called at posedge+1 with inputs already driven; checks at the negedge, returns at next posedge+1.
   task automatic step();
      logic [N-1:0] exp_ready;
      logic         exp_valid;
      int           g;
      @(negedge clk);
      cyc++;
      exp_ready = '0;
      g = m_busy ? -1 : ref_pick(bus.req_valid, m_ptr);
      if (g >= 0) exp_ready[g] = 1'b1;
      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      exp_valid = m_busy && (cyc >= m_acc + 2);
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
         check_eq("rsp_id", 32'(bus.rsp_id), 32'(m_id));
         check_eq("rsp_flags", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'(ref_flags(m_a, m_b)));
      end
      if (exp_valid && bus.rsp_ready) begin
         m_busy = 1'b0;
      end else if (g >= 0) begin
         m_busy = 1'b1;
         m_acc  = cyc;
         m_id   = g;
         m_a    = int'(bus.req_a[g*W +: W]);
         m_b    = int'(bus.req_b[g*W +: W]);
         m_ptr  = (g + 1) % N;
         acc_log.push_back(g);
         acc_cyc_log.push_back(cyc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.rsp_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_busy = 1'b0;
      m_ptr  = 0;
   endtask

   task automatic drain();
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      #1;
      check_eq("reset_req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
      check_eq("reset_flags", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'd0);
      do_reset();

      // Single requester 0, 9 vs 3.
      bus.req_valid = 4'b0001;
      bus.req_a     = 16'h0009;
      bus.req_b     = 16'h0003;
      bus.rsp_ready = 1'b1;
      step();
      bus.req_valid = '0;
      step();
      check_eq("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("t1_rsp_id", 32'(bus.rsp_id), 32'd0);
      check_eq("t1_flags", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'b100);
      drain();

      // All requesters continuously valid with equal operands.
      do_reset();
      acc_log.delete();
      acc_cyc_log.delete();
      bus.req_valid = 4'b1111;
      bus.req_a     = 16'h5555;
      bus.req_b     = 16'h5555;
      bus.rsp_ready = 1'b1;
      repeat (14) step();
      check_eq("t2_accept_count", 32'(acc_log.size() >= 5), 32'd1);
      for (int i = 0; i < 5 && i < acc_log.size(); i++) begin
         check_eq("t2_grant_order", 32'(acc_log[i]), 32'(i % N));
         if (i > 0) check_eq("t2_spacing", 32'(acc_cyc_log[i] - acc_cyc_log[i-1]), 32'd3);
      end
      drain();

      // Stalled response: held stable with no grants while rsp_ready is low.
      bus.req_valid = 4'b0001;
      bus.req_a     = 16'h000c;
      bus.req_b     = 16'h000d;
      bus.rsp_ready = 1'b0;
      repeat (8) step();
      bus.rsp_ready = 1'b1;
      repeat (3) step();
      drain();

      // Operands change the cycle after acceptance; captured value must win.
      bus.req_valid = 4'b0100;
      bus.req_a     = 16'h0100;
      bus.req_b     = 16'h0800;
      bus.rsp_ready = 1'b1;
      step();
      bus.req_valid      = '0;
      bus.req_a[8 +: 4]  = 4'd15;
      step();
      check_eq("t4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("t4_rsp_id", 32'(bus.rsp_id), 32'd2);
      check_eq("t4_flags", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'b010);
      drain();

      // Reset during CMP discards the operation and rewinds the pointer.
      bus.req_valid = 4'b0010;
      bus.req_a     = 16'h0070;
      bus.req_b     = 16'h0010;
      step();
      bus.req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t5_req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("t5_rsp_id", 32'(bus.rsp_id), 32'd0);
      check_eq("t5_flags", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'd0);
      m_busy = 1'b0;
      m_ptr  = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.req_valid = 4'b1010;
      step();
      check_eq("t5_first_grant", 32'(acc_log[$]), 32'd1);
      drain();

      // -1 vs 1: signed build says lt, unsigned build says gt.
      bus.req_valid = 4'b0001;
      bus.req_a     = 16'h000f;
      bus.req_b     = 16'h0001;
      step();
      bus.req_valid = '0;
      step();
`ifdef CMP_ARB_SIGNED_EN
      check_eq("t6_flags", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'b010);
`else
      check_eq("t6_flags", 32'({bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}), 32'b100);
`endif
      drain();

      // Random traffic: valids may drop unaccepted, operands churn, consumer stalls.
      for (int i = 0; i < 400; i++) begin
         bus.req_valid = N'($urandom_range(0, 15));
         bus.req_a     = 16'($urandom);
         bus.req_b     = 16'($urandom);
         bus.rsp_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
